reg_file_bypass: RTL
====================

Name: reg_file_bypass

Overview:
- Parametrised general-purpose register file for the CPU decode stage.
- Generalises the plain 2-read/1-write file with byte-strobed writes, same-cycle write-to-read bypass, a hardwired-zero register option and a per-register busy scoreboard for hazard detection.
- Sits between decode (reads, busy set on issue) and writeback (writes, busy clear).

Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy; 0 = register 0 is an ordinary register.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports; 0 = reads return stored state only.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- waddr  in  ADDR_WIDTH  write address.
- wen  in  1  write enable.
- wstrb  in  DATA_WIDTH/8  byte write strobes; bit k covers bits [8k+7:8k].
- wdata  in  DATA_WIDTH  write data.
- raddr1  in  ADDR_WIDTH  read address, port 1.
- raddr2  in  ADDR_WIDTH  read address, port 2.
- rdata1  out  DATA_WIDTH  read data, port 1 (combinational).
- rdata2  out  DATA_WIDTH  read data, port 2 (combinational).
- bset_en  in  1  mark a register busy (producer issued).
- bset_addr  in  ADDR_WIDTH  register to mark busy.
- busy1  out  1  busy flag for raddr1 (registered state, no bypass).
- busy2  out  1  busy flag for raddr2.
- any_busy  out  1  OR of all busy flags.

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers clear to 0 and all busy flags clear to 0 immediately, without a clock edge;
  - rdata1/rdata2 read 0; busy1, busy2 and any_busy are 0.
  - Reset mid-operation discards any write in that cycle.
- Write: on the rising edge with wen=1, bytes of reg[waddr] whose strobe is 1 take wdata; other bytes are unchanged.
  - wen=1 with wstrb=0 changes no data but still clears busy.
- Zero register (ZERO_REG=1): writes and busy-sets to address 0 are ignored; rdata returns 0 for raddr=0; busy for address 0 is constantly 0.
- Read, zero latency:
  - rdataN = reg[raddrN] by default.
  - If BYPASS=1, wen=1, waddr==raddrN and the address is not a hardwired zero: rdataN = merge(old reg, wdata, wstrb), i.e. exactly the value the register will hold after the edge.
  - Both read ports bypass independently and may target the same address.
- Busy scoreboard, one flag per register, updated on the rising edge:
  - wen=1 to address A clears busy[A];
  - bset_en=1 to address B sets busy[B];
  - when A==B in the same cycle, set wins (a new producer supersedes the completing one);
  - bset_en to an already busy register keeps it busy (no counting, single outstanding producer per register).
- busyN = busy[raddrN] as currently stored; a clear in the current cycle is visible the next cycle. Decode may combine this with rdata bypass externally.
- any_busy = OR of all busy flags, combinational from state.
- X-free: reads of never-written registers return 0 after reset.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH constants;
  - the strobe-width function (DATA_WIDTH/8);
  - the byte-merge function merge(old, new, strb), used by both the write path and the bypass so they cannot diverge.
- One natural sub-module, reg_scoreboard: busy flag array, set/clear priority, busy1/busy2/any_busy outputs.
- The data array and bypass muxes stay in reg_file_bypass.

Test Plan:
- Assert rst=0 mid-run after writing reg 5 = 0xDEADBEEF -> rdata1 for raddr1=5 is 0 immediately, before any clock edge; busy1=0; any_busy=0.
- wen=1, waddr=3, wstrb=0xF, wdata=0x12345678, raddr1=3 in the same cycle -> rdata1=0x12345678 combinationally (BYPASS=1). Next cycle with wen=0 -> still 0x12345678. With BYPASS=0 -> old value 0 in the write cycle.
- reg 7 = 0xAABBCCDD; write wstrb=0x5, wdata=0x11223344 -> reg 7 = 0xAA22CC44; bypassed rdata2 in the write cycle is also 0xAA22CC44.
- Write 0xFFFFFFFF to address 0 and bset_en to address 0 with ZERO_REG=1 -> rdata1=0, busy1=0, any_busy=0. With ZERO_REG=0 -> rdata1=0xFFFFFFFF.
- bset_en to 9 -> next cycle busy1=1 (raddr1=9), any_busy=1. Then wen to 9 and bset_en to 9 in the same cycle -> busy stays 1. Then wen to 9 alone -> busy1=0 next cycle, any_busy=0.
- Both read ports on address 4 during a write of 0x0000BEEF with strobes 0x3 to register 4 (old value 0x12340000) -> rdata1 = rdata2 = 0x1234BEEF.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and the byte-merge helper used by both the register write path and read bypass.
// Sharing one merge function keeps the stored value and the forwarded value bit-identical.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  // Works at MAX_DATA_WIDTH; callers zero-extend the operands and truncate the result.
  function automatic logic [MAX_DATA_WIDTH-1:0] merge(
    input logic [MAX_DATA_WIDTH-1:0] old_val,
    input logic [MAX_DATA_WIDTH-1:0] new_val,
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] res;
    res = old_val;
    for (int k = 0; k < MAX_STRB_WIDTH; k++) begin
      if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy flags: set on issue, cleared by writeback, set wins on a same-cycle collision.
// Flags update on the rising edge; busy1/busy2/any_busy are combinational from stored state.
module reg_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  bset_en,
  input  logic [ADDR_WIDTH-1:0] bset_addr,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  any_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0] busy;
  logic             clr_en;
  logic             set_en;

  assign clr_en = wen     && !((ZERO_REG != 0) && (waddr     == '0));
  assign set_en = bset_en && !((ZERO_REG != 0) && (bset_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[waddr] <= 1'b0;
      // Issued after the clear so a new producer supersedes the completing one.
      if (set_en) busy[bset_addr] <= 1'b1;
    end
  end

  assign busy1    = busy[raddr1];
  assign busy2    = busy[raddr2];
  assign any_busy = |busy;

endmodule

// File: rtl/reg_file_bypass.sv
// 2-read/1-write register file with byte strobes, optional hardwired r0 and same-cycle write bypass.
// Reads are zero latency; writes land on the rising edge; no backpressure, every write is accepted.
module reg_file_bypass import regfile_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_WIDTH-1:0]             waddr,
  input  logic                              wen,
  input  logic [strb_width(DATA_WIDTH)-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic [ADDR_WIDTH-1:0]             raddr1,
  input  logic [ADDR_WIDTH-1:0]             raddr2,
  output logic [DATA_WIDTH-1:0]             rdata1,
  output logic [DATA_WIDTH-1:0]             rdata2,
  input  logic                              bset_en,
  input  logic [ADDR_WIDTH-1:0]             bset_addr,
  output logic                              busy1,
  output logic                              busy2,
  output logic                              any_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  wr_live;
  logic                  wr_zero;
  logic [DATA_WIDTH-1:0] wr_val;

  // A write during reset is discarded, so it must not be forwarded either.
  assign wr_live = wen & rst;
  assign wr_zero = (ZERO_REG != 0) && (waddr == '0);
  assign wr_val  = DATA_WIDTH'(merge(MAX_DATA_WIDTH'(regs[waddr]),
                                     MAX_DATA_WIDTH'(wdata),
                                     MAX_STRB_WIDTH'(wstrb)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_live && !wr_zero) begin
      regs[waddr] <= wr_val;
    end
  end

  always_comb begin
    rdata1 = regs[raddr1];
    if ((ZERO_REG != 0) && (raddr1 == '0))
      rdata1 = '0;
    else if ((BYPASS != 0) && wr_live && (waddr == raddr1))
      rdata1 = wr_val;
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if ((ZERO_REG != 0) && (raddr2 == '0))
      rdata2 = '0;
    else if ((BYPASS != 0) && wr_live && (waddr == raddr2))
      rdata2 = wr_val;
  end

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wen       (wen),
    .waddr     (waddr),
    .bset_en   (bset_en),
    .bset_addr (bset_addr),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .busy1     (busy1),
    .busy2     (busy2),
    .any_busy  (any_busy)
  );

endmodule
